// File: rtl/sm83_pkg.sv
// Shared SM83 types and constants used by the interrupt controller.
package sm83_pkg;

    typedef logic [15:0] addr_t;
    typedef addr_t irq_vec_t;

    typedef enum logic [0:0] {
        IRQ_IDLE,
        IRQ_VEC
    } irq_state_t;

    localparam addr_t IF_ADDR = 16'hFF0F;
    localparam addr_t IE_ADDR = 16'hFFFF;

    // Vector for channel sel; 16-bit wrap-around arithmetic, sel zero-extended.
    function automatic irq_vec_t irq_vector(addr_t base, addr_t stride, logic [2:0] sel);
        return base + (addr_t'(sel) * stride);
    endfunction

endpackage

// File: rtl/sm83_prio_enc.sv
// Lowest-index-first priority encoder for up to 8 request lines.
module sm83_prio_enc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] req,
    output logic [2:0]       idx,
    output logic             valid
);

    // Scan from the top down so the lowest set bit is the last one to assign.
    always_comb begin
        idx   = 3'd0;
        valid = 1'b0;
        for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx   = 3'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sm83_irq_ctrl.sv
// SM83 interrupt controller: IF/IE registers, IME handling and dispatch handshake.
module sm83_irq_ctrl
    import sm83_pkg::*;
#(
    parameter int unsigned N_IRQ      = 5,
    parameter logic [15:0] VEC_BASE   = 16'h0040,
    parameter int unsigned VEC_STRIDE = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic [15:0]      bus_addr,
    input  logic [7:0]       bus_wdata,
    input  logic             bus_we,
    output logic [7:0]       bus_rdata,
    output logic             bus_hit,
    input  logic             ime_set,
    input  logic             ime_set_now,
    input  logic             ime_clr,
    input  logic             instr_boundary,
    output logic             irq_pending,
    output logic             irq_req,
    input  logic             irq_ack,
    output logic [15:0]      irq_vec,
    output logic [2:0]       irq_id,
    input  logic             vec_taken
);

    logic [N_IRQ-1:0] src_q;
    logic [N_IRQ-1:0] if_q, if_d;
    logic [N_IRQ-1:0] ie_q, ie_d;
    logic             ime_q, ime_d;
    logic             ei_pend_q, ei_pend_d;
    irq_state_t       state_q, state_d;
    irq_vec_t         vec_q, vec_d;
    logic [2:0]       id_q, id_d;

    logic [N_IRQ-1:0] set_pulse;
    logic [N_IRQ-1:0] pend_vec;
    logic [2:0]       sel;
    logic             sel_valid;
    logic             dispatch;
    logic             wr_if, wr_ie;
    logic             unused_wdata;

    assign set_pulse = irq_src & ~src_q;
    assign pend_vec  = if_q & ie_q;
    assign dispatch  = (state_q == IRQ_IDLE) && irq_ack;
    assign wr_if     = bus_we && (bus_addr == IF_ADDR);
    assign wr_ie     = bus_we && (bus_addr == IE_ADDR);

    // Upper write-data bits are ignored when fewer than 8 channels exist.
    assign unused_wdata = ^bus_wdata;

    sm83_prio_enc #(
        .WIDTH (N_IRQ)
    ) u_prio_enc (
        .req   (pend_vec),
        .idx   (sel),
        .valid (sel_valid)
    );

    // State registers; src_q resets high so a line held through reset never requests.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q     <= '1;
            if_q      <= '0;
            ie_q      <= '0;
            ime_q     <= 1'b0;
            ei_pend_q <= 1'b0;
            state_q   <= IRQ_IDLE;
            vec_q     <= '0;
            id_q      <= '0;
        end else begin
            src_q     <= irq_src;
            if_q      <= if_d;
            ie_q      <= ie_d;
            ime_q     <= ime_d;
            ei_pend_q <= ei_pend_d;
            state_q   <= state_d;
            vec_q     <= vec_d;
            id_q      <= id_d;
        end
    end

    // IF/IE next state: bus write, then dispatch clear, then source edges win.
    always_comb begin
        if_d = if_q;
        ie_d = ie_q;
        if (wr_if) if_d = bus_wdata[N_IRQ-1:0];
        if (wr_ie) ie_d = bus_wdata[N_IRQ-1:0];
        if (dispatch && sel_valid) begin
            for (int i = 0; i < int'(N_IRQ); i++) begin
                if (sel == 3'(i)) if_d[i] = 1'b0;
            end
        end
        if_d = if_d | set_pulse;
    end

    // IME next state: EI takes effect at a later boundary; DI and dispatch dominate.
    always_comb begin
        ime_d     = ime_q;
        ei_pend_d = ei_pend_q;
        if (ei_pend_q && instr_boundary) begin
            ime_d     = 1'b1;
            ei_pend_d = 1'b0;
        end
        if (ime_set_now) ime_d = 1'b1;
        if (ime_set) ei_pend_d = 1'b1;
        if (ime_clr || dispatch) begin
            ime_d     = 1'b0;
            ei_pend_d = 1'b0;
        end
    end

    // Dispatch FSM; sel uses the pre-write IF/IE of the ack cycle.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        id_d    = id_q;
        unique case (state_q)
            IRQ_IDLE: begin
                if (irq_ack) begin
                    state_d = IRQ_VEC;
                    if (sel_valid) begin
                        vec_d = irq_vector(VEC_BASE, 16'(VEC_STRIDE), sel);
                        id_d  = sel;
                    end else begin
                        vec_d = '0;
                        id_d  = '0;
                    end
                end
            end
            IRQ_VEC: begin
                if (vec_taken) state_d = IRQ_IDLE;
            end
            default: state_d = IRQ_IDLE;
        endcase
    end

    // Bus read mux: unused IF bits read as 1, unused IE bits as 0.
    always_comb begin
        logic [7:0] if_rd;
        logic [7:0] ie_rd;
        if_rd = 8'hFF;
        ie_rd = 8'h00;
        if_rd[N_IRQ-1:0] = if_q;
        ie_rd[N_IRQ-1:0] = ie_q;
        bus_hit   = (bus_addr == IF_ADDR) || (bus_addr == IE_ADDR);
        bus_rdata = 8'h00;
        if (bus_addr == IF_ADDR) bus_rdata = if_rd;
        else if (bus_addr == IE_ADDR) bus_rdata = ie_rd;
    end

    assign irq_pending = |pend_vec;
    assign irq_req     = irq_pending && ime_q && (state_q == IRQ_IDLE);
    assign irq_vec     = vec_q;
    assign irq_id      = id_q;

endmodule

// File: tb/tb_sm83_irq_ctrl.sv
// Bench for sm83_irq_ctrl: directed scenarios plus random traffic against a model.
module tb_sm83_irq_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [4:0]  a_src;
    logic [7:0]  b_src;
    logic [15:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic        bus_we, ime_set, ime_set_now, ime_clr, instr_boundary, irq_ack, vec_taken;

    logic [7:0]  a_rdata, b_rdata;
    logic        a_hit, b_hit, a_pend, b_pend, a_req, b_req;
    logic [15:0] a_vec, b_vec;
    logic [2:0]  a_id, b_id;

    int total = 0;
    int bad = 0;

    sm83_irq_ctrl #(.N_IRQ(5), .VEC_BASE(16'h0040), .VEC_STRIDE(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .irq_src(a_src), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(a_rdata), .bus_hit(a_hit),
        .ime_set(ime_set), .ime_set_now(ime_set_now), .ime_clr(ime_clr),
        .instr_boundary(instr_boundary), .irq_pending(a_pend), .irq_req(a_req),
        .irq_ack(irq_ack), .irq_vec(a_vec), .irq_id(a_id), .vec_taken(vec_taken)
    );

    sm83_irq_ctrl #(.N_IRQ(8), .VEC_BASE(16'h0040), .VEC_STRIDE(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .irq_src(b_src), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_we(bus_we), .bus_rdata(b_rdata), .bus_hit(b_hit),
        .ime_set(ime_set), .ime_set_now(ime_set_now), .ime_clr(ime_clr),
        .instr_boundary(instr_boundary), .irq_pending(b_pend), .irq_req(b_req),
        .irq_ack(irq_ack), .irq_vec(b_vec), .irq_id(b_id), .vec_taken(vec_taken)
    );

    // Reference model of the 5-channel instance.
    bit [7:0]  m_if, m_ie, m_src;
    bit        m_ime, m_ep, m_vec;
    bit [15:0] m_vaddr;
    bit [2:0]  m_id;

    task automatic model_reset();
        m_if = 0; m_ie = 0; m_src = 8'hFF; m_ime = 0; m_ep = 0; m_vec = 0;
        m_vaddr = 0; m_id = 0;
    endtask

    task automatic model_clock();
        bit [7:0] nif, nie;
        int sel;
        bit disp;
        nif = m_if; nie = m_ie; sel = -1;
        disp = irq_ack && !m_vec;
        if (disp) for (int k = 4; k >= 0; k--) if (m_if[k] && m_ie[k]) sel = k;
        if (bus_we && bus_addr == 16'hFF0F) nif = bus_wdata & 8'h1F;
        if (bus_we && bus_addr == 16'hFFFF) nie = bus_wdata & 8'h1F;
        if (disp) begin
            if (sel >= 0) begin
                nif[sel] = 1'b0;
                m_vaddr = 16'h0040 + 16'(sel * 8);
                m_id = 3'(sel);
            end else begin
                m_vaddr = 16'h0000;
                m_id = 3'd0;
            end
            m_vec = 1;
        end else if (m_vec && vec_taken) begin
            m_vec = 0;
        end
        nif = nif | ({3'b000, a_src} & ~m_src);
        m_src = {3'b000, a_src};
        if (disp || ime_clr) begin
            m_ime = 0; m_ep = 0;
        end else begin
            if (m_ep && instr_boundary) begin m_ime = 1; m_ep = 0; end
            if (ime_set_now) m_ime = 1;
            if (ime_set) m_ep = 1;
        end
        m_if = nif; m_ie = nie;
    endtask

    task automatic step();
        if (!rst_n) model_reset(); else model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus_addr = 16'h0000; bus_wdata = 8'h00; bus_we = 0; ime_set = 0; ime_set_now = 0;
        ime_clr = 0; instr_boundary = 0; irq_ack = 0; vec_taken = 0;
    endtask

    task automatic write_reg(input logic [15:0] addr, input logic [7:0] data);
        bus_addr = addr; bus_wdata = data; bus_we = 1;
        step();
        bus_we = 0; bus_addr = 16'h0000;
    endtask

    task automatic read_reg(input logic [15:0] addr, output logic [7:0] d);
        bus_addr = addr; bus_we = 0;
        #1;
        d = a_rdata;
    endtask

    task automatic test_reset();
        logic [7:0] d;
        idle(); a_src = 5'h08; b_src = 8'h80; rst_n = 0; model_reset();
        #2;
        total++; if (a_pend !== 1'b0) begin bad++; $display("FAIL reset_pend: got %b want 0", a_pend); end
        total++; if (a_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", a_req); end
        total++; if (a_vec !== 16'h0000 || a_id !== 3'd0) begin bad++;
            $display("FAIL reset_vec: got %h/%0d want 0000/0", a_vec, a_id); end
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hE0 || a_hit !== 1'b1) begin bad++;
            $display("FAIL reset_if: got %h hit %b want e0 hit 1", d, a_hit); end
        read_reg(16'hFFFF, d);
        total++; if (d !== 8'h00 || a_hit !== 1'b1) begin bad++;
            $display("FAIL reset_ie: got %h hit %b want 00 hit 1", d, a_hit); end
        read_reg(16'hC123, d);
        total++; if (d !== 8'h00 || a_hit !== 1'b0) begin bad++;
            $display("FAIL reset_other: got %h hit %b want 00 hit 0", d, a_hit); end
        @(negedge clk); rst_n = 1;
        step(); step();
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hE0) begin bad++; $display("FAIL held_src: got %h want e0", d); end
        a_src = 0; b_src = 0; step();
    endtask

    task automatic test_basic();
        logic [7:0] d;
        write_reg(16'hFFFF, 8'h04);
        ime_set_now = 1; step(); ime_set_now = 0;
        a_src[2] = 1; step();
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hE4) begin bad++; $display("FAIL basic_if: got %h want e4", d); end
        total++; if (a_req !== 1'b1) begin bad++; $display("FAIL basic_req: got %b want 1", a_req); end
        irq_ack = 1; step(); irq_ack = 0;
        total++; if (a_vec !== 16'h0050 || a_id !== 3'd2) begin bad++;
            $display("FAIL basic_vec: got %h/%0d want 0050/2", a_vec, a_id); end
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hE0) begin bad++; $display("FAIL basic_ifclr: got %h want e0", d); end
        vec_taken = 1; step(); vec_taken = 0;
        write_reg(16'hFF0F, 8'h04);
        total++; if (a_pend !== 1'b1 || a_req !== 1'b0) begin bad++;
            $display("FAIL basic_imeclr: got pend %b req %b want 1 0", a_pend, a_req); end
        a_src = 0; step();
    endtask

    task automatic test_priority();
        logic [7:0] d;
        write_reg(16'hFF0F, 8'h1F);
        write_reg(16'hFFFF, 8'h1A);
        ime_set_now = 1; step(); ime_set_now = 0;
        irq_ack = 1; step(); irq_ack = 0;
        total++; if (a_vec !== 16'h0048 || a_id !== 3'd1) begin bad++;
            $display("FAIL prio_vec: got %h/%0d want 0048/1", a_vec, a_id); end
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hFD) begin bad++; $display("FAIL prio_if: got %h want fd", d); end
        vec_taken = 1; step(); vec_taken = 0;
    endtask

    task automatic test_ei_delay();
        write_reg(16'hFF0F, 8'h00);
        write_reg(16'hFFFF, 8'h01);
        ime_set = 1; a_src[0] = 1; step(); ime_set = 0;
        total++; if (a_pend !== 1'b1 || a_req !== 1'b0) begin bad++;
            $display("FAIL ei_early: got pend %b req %b want 1 0", a_pend, a_req); end
        step(); step();
        instr_boundary = 1;
        total++; if (a_req !== 1'b0) begin bad++; $display("FAIL ei_wait: got %b want 0", a_req); end
        step(); instr_boundary = 0;
        total++; if (a_req !== 1'b1) begin bad++; $display("FAIL ei_on: got %b want 1", a_req); end
        ime_clr = 1; step(); ime_clr = 0;
        ime_set = 1; instr_boundary = 1; step(); ime_set = 0;
        total++; if (a_req !== 1'b0) begin bad++; $display("FAIL ei_same: got %b want 0", a_req); end
        step(); instr_boundary = 0;
        total++; if (a_req !== 1'b1) begin bad++; $display("FAIL ei_next: got %b want 1", a_req); end
        ime_clr = 1; step(); ime_clr = 0;
        ime_set = 1; step(); ime_set = 0;
        instr_boundary = 1; ime_clr = 1; step(); ime_clr = 0;
        step(); instr_boundary = 0;
        total++; if (a_req !== 1'b0) begin bad++; $display("FAIL di_wins: got %b want 0", a_req); end
    endtask

    task automatic test_halt_wake();
        a_src = 0; write_reg(16'hFF0F, 8'h00);
        a_src[0] = 1; step();
        total++; if (a_pend !== 1'b1 || a_req !== 1'b0) begin bad++;
            $display("FAIL halt_wake: got pend %b req %b want 1 0", a_pend, a_req); end
    endtask

    task automatic test_ack_write();
        logic [7:0] d;
        ime_set_now = 1; step(); ime_set_now = 0;
        irq_ack = 1; bus_we = 1; bus_addr = 16'hFFFF; bus_wdata = 8'h00; step();
        irq_ack = 0; bus_we = 0;
        total++; if (a_vec !== 16'h0040 || a_id !== 3'd0) begin bad++;
            $display("FAIL ackwr_vec: got %h/%0d want 0040/0", a_vec, a_id); end
        vec_taken = 1; step(); vec_taken = 0;
        write_reg(16'hFF0F, 8'h01);
        write_reg(16'hFFFF, 8'h01);
        ime_set_now = 1; step(); ime_set_now = 0;
        write_reg(16'hFFFF, 8'h00);
        irq_ack = 1; step(); irq_ack = 0;
        total++; if (a_vec !== 16'h0000 || a_id !== 3'd0) begin bad++;
            $display("FAIL cancel_vec: got %h/%0d want 0000/0", a_vec, a_id); end
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hE1) begin bad++; $display("FAIL cancel_if: got %h want e1", d); end
        vec_taken = 1; step(); vec_taken = 0;
        a_src = 0; step();
    endtask

    task automatic test_collision();
        logic [7:0] d;
        write_reg(16'hFFFF, 8'h02);
        write_reg(16'hFF0F, 8'h02);
        ime_set_now = 1; step(); ime_set_now = 0;
        irq_ack = 1; a_src[1] = 1; bus_we = 1; bus_addr = 16'hFF0F; bus_wdata = 8'h00; step();
        irq_ack = 0; bus_we = 0;
        total++; if (a_id !== 3'd1) begin bad++; $display("FAIL coll_id: got %0d want 1", a_id); end
        read_reg(16'hFF0F, d);
        total++; if (d !== 8'hE2) begin bad++; $display("FAIL coll_if: got %h want e2", d); end
        vec_taken = 1; step(); vec_taken = 0;
        a_src = 0; step();
    endtask

    task automatic test_wide();
        write_reg(16'hFFFF, 8'h80);
        ime_set_now = 1; b_src[7] = 1; step(); ime_set_now = 0;
        total++; if (b_req !== 1'b1) begin bad++; $display("FAIL wide_req: got %b want 1", b_req); end
        irq_ack = 1; step(); irq_ack = 0;
        total++; if (b_vec !== 16'h00B0 || b_id !== 3'd7) begin bad++;
            $display("FAIL wide_vec: got %h/%0d want 00b0/7", b_vec, b_id); end
        #2 rst_n = 0; model_reset();
        #1;
        total++; if (b_vec !== 16'h0000 || b_id !== 3'd0 || b_pend !== 1'b0) begin bad++;
            $display("FAIL wide_rst: got %h/%0d pend %b want 0000/0 0", b_vec, b_id, b_pend); end
        total++; if (a_vec !== 16'h0000 || a_req !== 1'b0) begin bad++;
            $display("FAIL rst_a: got %h req %b want 0000 0", a_vec, a_req); end
        b_src = 0; a_src = 0;
        @(negedge clk); rst_n = 1;
        step();
        // After reset the FSM must accept a fresh ack from IDLE.
        write_reg(16'hFFFF, 8'h80);
        b_src[7] = 1; ime_set_now = 1; step(); ime_set_now = 0;
        irq_ack = 1; step(); irq_ack = 0;
        total++; if (b_id !== 3'd7) begin bad++; $display("FAIL wide_again: got %0d want 7", b_id); end
        vec_taken = 1; step(); vec_taken = 0; b_src = 0; step();
    endtask

    task automatic test_random();
        int r;
        logic [7:0] want;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 3) == 0) a_src = a_src ^ 5'($urandom_range(0, 31));
            r = $urandom_range(0, 9);
            bus_addr = (r < 3) ? 16'hFF0F : (r < 6) ? 16'hFFFF : {8'hC0, 8'($urandom)};
            bus_we = ($urandom_range(0, 3) == 0);
            bus_wdata = 8'($urandom);
            ime_set = ($urandom_range(0, 7) == 0);
            ime_set_now = ($urandom_range(0, 9) == 0);
            ime_clr = ($urandom_range(0, 11) == 0);
            instr_boundary = ($urandom_range(0, 2) == 0);
            irq_ack = ($urandom_range(0, 3) == 0);
            vec_taken = ($urandom_range(0, 2) == 0);
            #1;
            want = (bus_addr == 16'hFF0F) ? (8'hE0 | m_if) : (bus_addr == 16'hFFFF) ? m_ie : 8'h00;
            total++; if (a_rdata !== want || a_hit !== (r < 6)) begin bad++;
                $display("FAIL rnd_bus c=%0d: got %h hit %b want %h hit %b", c, a_rdata, a_hit,
                         want, (r < 6)); end
            total++; if (a_pend !== |(m_if & m_ie)) begin bad++;
                $display("FAIL rnd_pend c=%0d: got %b want %b", c, a_pend, |(m_if & m_ie)); end
            total++; if (a_req !== (|(m_if & m_ie) && m_ime && !m_vec)) begin bad++;
                $display("FAIL rnd_req c=%0d: got %b want %b", c, a_req,
                         (|(m_if & m_ie) && m_ime && !m_vec)); end
            if (m_vec) begin
                total++; if (a_vec !== m_vaddr || a_id !== m_id) begin bad++;
                    $display("FAIL rnd_vec c=%0d: got %h/%0d want %h/%0d", c, a_vec, a_id,
                             m_vaddr, m_id); end
            end
            step();
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_ei_delay();
        test_halt_wake();
        test_ack_write();
        test_collision();
        test_wide();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sm83_irq_ctrl.md
# sm83_irq_ctrl

Parametrised interrupt controller for the SM83 core: it latches up to N_IRQ edge-triggered requests into IF, masks them with IE and gates them with IME. It runs the dispatch handshake with the core's control unit and supplies the vector address. It sits beside the register file on the core-side bus, owns the IF (0xFF0F) and IE (0xFFFF) registers, and generalises the fixed 5-source Game Boy scheme in channel count, vector base and vector stride.

## Interface
Parameters:
- N_IRQ, 5: number of request channels, 1..8; channel 0 has highest priority.
- VEC_BASE, 16'h0040: vector address of channel 0.
- VEC_STRIDE, 8: address step between consecutive channel vectors.

Ports (one clock; reset is asynchronous and active-low, ports `clk` / `rst_n`):
- clk  in  1  core clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_src  in  N_IRQ  level request lines; a rising edge sets the IF bit.
- bus_addr  in  16  core bus address.
- bus_wdata  in  8  write data.
- bus_we  in  1  write strobe, one cycle per write.
- bus_rdata  out  8  combinational read data for IF/IE; 8'h00 for any other address.
- bus_hit  out  1  bus_addr decodes to IF or IE.
- ime_set  in  1  EI executed; enables IME after one instruction.
- ime_set_now  in  1  RETI executed; enables IME immediately.
- ime_clr  in  1  DI executed.
- instr_boundary  in  1  pulse when the core fetches the next opcode.
- irq_pending  out  1  |(IE & IF), regardless of IME; this is the HALT wake.
- irq_req  out  1  irq_pending & IME & state==IDLE.
- irq_ack  in  1  core starts dispatch (M-cycle that pushes PC).
- irq_vec  out  16  vector address; valid while state==VEC.
- irq_id  out  3  dispatched channel index; valid while state==VEC.
- vec_taken  in  1  core has loaded irq_vec into PC.

## Operation
- Edge detect: per-channel src_q register; a set pulse is generated on irq_src & ~src_q.
- IF/IE writes: a write to IF or IE at bus_we stores the low N_IRQ bits. bus_rdata for IF = {1s in bits 7..N_IRQ, IF}; bus_rdata for IE = {0s in bits 7..N_IRQ, IE}.
- IME:
  - ime_clr clears IME and ei_pend at once.
  - ime_set sets ei_pend; IME becomes 1 on the next instr_boundary after ei_pend is set, not in the same cycle.
  - ime_set_now sets IME at once.
  - When several fire in one cycle, ime_clr wins.
- FSM with states IDLE and VEC:
  - IDLE, irq_ack: sel = lowest index of IE & IF, sampled in the ack cycle. If a channel is selected, clear IF[sel], set irq_vec = VEC_BASE + sel*VEC_STRIDE and irq_id = sel. If none is selected (request cancelled by an IE/IF write), set irq_vec = 16'h0000 and irq_id = 0. In both cases clear IME and ei_pend, then go to VEC.
  - VEC, vec_taken: go to IDLE. irq_ack is ignored while in VEC.
- Vector arithmetic is 16-bit, and sel*VEC_STRIDE is zero-extended.

## Timing
- Reset values: IF=0, IE=0, IME=0, ei_pend=0, src_q=all 1s (a line held high through reset does not request), state=IDLE, irq_vec=0, irq_id=0.
- Outputs at reset: irq_req=0, irq_pending=0, bus_hit and bus_rdata per address.
- Latency:
  - A source rising edge at cycle t sets IF at t+1.
  - irq_pending and irq_req follow combinationally from the registers, so they rise at t+1.
  - irq_vec is valid the cycle after irq_ack.
- Same-cycle collisions on one IF bit: a source edge wins over a bus write of 0 and over the dispatch clear, so the bit ends set.
- A bus write to IE or IF in the ack cycle does not affect sel, which uses the pre-write values.
- rst_n asserted mid-dispatch returns the FSM to IDLE at once, clears everything, and drops irq_vec to 0.

## Structure
- Add to sm83_pkg:
  - irq_state_t {IRQ_IDLE, IRQ_VEC}
  - localparams IF_ADDR=16'hFF0F and IE_ADDR=16'hFFFF
  - typedef irq_vec_t = addr_t
- Sub-module sm83_prio_enc: parametrised by width, outputs lowest-set index plus a valid bit; purely combinational.

## Test plan
- Raise irq_src[2] with IE=8'h04 and IME=1 -> IF=8'hE4 the next cycle, irq_req=1. After irq_ack -> irq_vec=16'h0050, irq_id=2, IF bit 2 cleared, IME=0.
- Set IF=8'h1F and IE=8'h1A, then irq_ack -> channel 1 dispatched, irq_vec=16'h0048. The remaining bits stay set.
- Pulse ime_set and issue a request in the same cycle -> irq_req=0 until the first instr_boundary, then 1. ime_clr in the boundary cycle keeps IME=0.
- Hold IME=0, IE=8'h01, and raise irq_src[0] -> irq_pending=1, irq_req=0 (HALT wake only).
- Write IE=0 in the irq_ack cycle -> the dispatch uses the old IE. Write IE=0 the cycle before irq_ack -> irq_vec=16'h0000.
- Instance with N_IRQ=8, VEC_STRIDE=16, and raise channel 7 -> irq_vec=16'h00B0. Drive rst_n low while in VEC -> FSM returns to IDLE and irq_vec=0.
